// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
// Holds the FSM state encoding, requester identifiers and counter sizing.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: diff = a - b - bin, bout set when the bit borrows.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_arb.sv
// Two-requester round-robin front end that time-shares one full_sub cell,
// subtracting W-bit operands LSB-first and returning the result over valid/ready.
module serial_sub_arb
    import serial_sub_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_diff,
    output logic         res_borrow,
    output logic         res_id,
    output logic         busy
);

    localparam int CW = (clog2(W) < 1) ? 1 : clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  a_sr_q, a_sr_d;
    logic [W-1:0]  b_sr_q, b_sr_d;
    logic [W-1:0]  r_sr_q, r_sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bw_q, bw_d;
    logic          id_q, id_d;
    logic          rr_q, rr_d;
    logic          res_valid_q, res_valid_d;
    logic          busy_q, busy_d;

    logic          gnt_vld;
    logic          gnt_id;
    logic          cell_diff;
    logic          cell_bout;
    logic [W-1:0]  r_shift;

    // Grants are only offered out of reset and in IDLE; rr_q names the favoured side on a tie.
    always_comb begin
        gnt_vld = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) begin
            gnt_id = rr_q;
        end else if (req1_valid) begin
            gnt_id = REQ1;
        end else begin
            gnt_id = REQ0;
        end
    end

    assign req0_ready = gnt_vld && (gnt_id == REQ0);
    assign req1_ready = gnt_vld && (gnt_id == REQ1);

    full_sub u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (bw_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    // Result register fills from the top so bit 0 lands in place after W shifts.
    generate
        for (genvar gi = 0; gi < W - 1; gi++) begin : g_rshift
            assign r_shift[gi] = r_sr_q[gi+1];
        end
    endgenerate
    assign r_shift[W-1] = cell_diff;

    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        r_sr_d      = r_sr_q;
        cnt_d       = cnt_q;
        bw_d        = bw_q;
        id_d        = id_q;
        rr_d        = rr_q;
        res_valid_d = res_valid_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    state_d = RUN;
                    a_sr_d  = (gnt_id == REQ1) ? req1_a : req0_a;
                    b_sr_d  = (gnt_id == REQ1) ? req1_b : req0_b;
                    r_sr_d  = '0;
                    cnt_d   = '0;
                    bw_d    = 1'b0;
                    id_d    = gnt_id;
                    rr_d    = ~gnt_id;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                r_sr_d = r_shift;
                bw_d   = cell_bout;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d     = DONE;
                    cnt_d       = '0;
                    res_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            r_sr_q      <= '0;
            cnt_q       <= '0;
            bw_q        <= 1'b0;
            id_q        <= 1'b0;
            rr_q        <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            r_sr_q      <= r_sr_d;
            cnt_q       <= cnt_d;
            bw_q        <= bw_d;
            id_q        <= id_d;
            rr_q        <= rr_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Borrow flop and id only move in RUN/IDLE, so they stay stable while DONE waits.
    assign res_valid  = res_valid_q;
    assign res_diff   = r_sr_q;
    assign res_borrow = bw_q;
    assign res_id     = id_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_sub_arb.sv
// Scoreboard bench for serial_sub_arb: W=8 and W=1 instances, directed vectors.
module tb_serial_sub_arb;

    typedef struct packed {
        logic [7:0] diff;
        logic       borrow;
        logic       id;
    } exp8_t;

    typedef struct packed {
        logic diff;
        logic borrow;
        logic id;
    } exp1_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       r0v8, r0rdy8, r1v8, r1rdy8;
    logic [7:0] r0a8, r0b8, r1a8, r1b8;
    logic       rv8, rr8, rb8, rid8, busy8;
    logic [7:0] rd8;

    logic       r0v1, r0rdy1, r1v1, r1rdy1;
    logic [0:0] r0a1, r0b1, r1a1, r1b1;
    logic       rv1, rr1, rb1, rid1, busy1;
    logic [0:0] rd1;

    exp8_t q8[$];
    exp1_t q1[$];
    int n_checks = 0;
    int n_fail   = 0;

    serial_sub_arb #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v8), .req0_ready(r0rdy8), .req0_a(r0a8), .req0_b(r0b8),
        .req1_valid(r1v8), .req1_ready(r1rdy8), .req1_a(r1a8), .req1_b(r1b8),
        .res_valid(rv8), .res_ready(rr8), .res_diff(rd8), .res_borrow(rb8),
        .res_id(rid8), .busy(busy8)
    );

    serial_sub_arb #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v1), .req0_ready(r0rdy1), .req0_a(r0a1), .req0_b(r0b1),
        .req1_valid(r1v1), .req1_ready(r1rdy1), .req1_a(r1a1), .req1_b(r1b1),
        .res_valid(rv1), .res_ready(rr1), .res_diff(rd1), .res_borrow(rb1),
        .res_id(rid1), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitors: pop the scoreboard on every accepted result, watch ready rules.
    always @(negedge clk) begin
        exp8_t e;
        if (rst_n) begin
            check("ready_excl8", {31'd0, r0rdy8 & r1rdy8}, 0);
            check("ready_busy8", {31'd0, (r0rdy8 | r1rdy8) & busy8}, 0);
            if (rv8 && rr8) begin
                if (q8.size() == 0) begin
                    check("unexpected_result8", 1, 0);
                end else begin
                    e = q8.pop_front();
                    check("res_diff8", {24'd0, rd8}, {24'd0, e.diff});
                    check("res_borrow8", {31'd0, rb8}, {31'd0, e.borrow});
                    check("res_id8", {31'd0, rid8}, {31'd0, e.id});
                    $display("W8 result diff=%0d borrow=%0d id=%0d", rd8, rb8, rid8);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp1_t e;
        if (rst_n) begin
            check("ready_excl1", {31'd0, r0rdy1 & r1rdy1}, 0);
            if (rv1 && rr1) begin
                if (q1.size() == 0) begin
                    check("unexpected_result1", 1, 0);
                end else begin
                    e = q1.pop_front();
                    check("res_diff1", {31'd0, rd1}, {31'd0, e.diff});
                    check("res_borrow1", {31'd0, rb1}, {31'd0, e.borrow});
                    check("res_id1", {31'd0, rid1}, {31'd0, e.id});
                    $display("W1 result diff=%0d borrow=%0d id=%0d", rd1, rb1, rid1);
                end
            end
        end
    end

    task automatic check_zero8(input string tag);
        check({tag, "_valid"}, {31'd0, rv8}, 0);
        check({tag, "_busy"}, {31'd0, busy8}, 0);
        check({tag, "_rdy0"}, {31'd0, r0rdy8}, 0);
        check({tag, "_rdy1"}, {31'd0, r1rdy8}, 0);
        check({tag, "_diff"}, {24'd0, rd8}, 0);
        check({tag, "_borrow"}, {31'd0, rb8}, 0);
        check({tag, "_id"}, {31'd0, rid8}, 0);
    endtask

    task automatic wait_ready8(input logic id, output bit got);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((id ? r1rdy8 : r0rdy8) === 1'b1) got = 1;
        end
        check("grant_wait8", {31'd0, got}, 1);
    endtask

    // Issue one op on dut8 and check the ready pulse and W-cycle latency.
    task automatic op8(input logic id, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic eb);
        bit got;
        exp8_t e;
        if (id) begin r1v8 = 1; r1a8 = a; r1b8 = b; end
        else    begin r0v8 = 1; r0a8 = a; r0b8 = b; end
        wait_ready8(id, got);
        if (got) begin
            e.diff = ed; e.borrow = eb; e.id = id;
            q8.push_back(e);
            $display("W8 issue id=%0d a=%0d b=%0d expect diff=%0d borrow=%0d", id, a, b, ed, eb);
            @(posedge clk);
            for (int m = 0; m <= 8; m++) begin
                @(negedge clk);
                if (m == 0) begin
                    check("ready_pulse8", {31'd0, id ? r1rdy8 : r0rdy8}, 0);
                    if (id) r1v8 = 0; else r0v8 = 0;
                end
                check("latency8", {31'd0, rv8}, {31'd0, (m == 8)});
            end
        end else begin
            if (id) r1v8 = 0; else r0v8 = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic op1(input logic id, input logic a, input logic b,
                       input logic ed, input logic eb);
        bit got;
        exp1_t e;
        got = 0;
        if (id) begin r1v1 = 1; r1a1 = a; r1b1 = b; end
        else    begin r0v1 = 1; r0a1 = a; r0b1 = b; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((id ? r1rdy1 : r0rdy1) === 1'b1) got = 1;
        end
        check("grant_wait1", {31'd0, got}, 1);
        if (got) begin
            e.diff = ed; e.borrow = eb; e.id = id;
            q1.push_back(e);
            $display("W1 issue id=%0d a=%0d b=%0d expect diff=%0d borrow=%0d", id, a, b, ed, eb);
            @(posedge clk);
            @(negedge clk);
            check("ready_pulse1", {31'd0, id ? r1rdy1 : r0rdy1}, 0);
            check("latency1_m0", {31'd0, rv1}, 0);
            if (id) r1v1 = 0; else r0v1 = 0;
            @(negedge clk);
            check("latency1_m1", {31'd0, rv1}, 1);
        end else begin
            if (id) r1v1 = 0; else r0v1 = 0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        exp8_t e;
        rst_n = 0;
        r0v8 = 0; r1v8 = 0; r0a8 = 0; r0b8 = 0; r1a8 = 0; r1b8 = 0; rr8 = 0;
        r0v1 = 0; r1v1 = 0; r0a1 = 0; r0b1 = 0; r1a1 = 0; r1b1 = 0; rr1 = 0;
        repeat (2) @(negedge clk);
        check_zero8("reset8");
        check("reset1_valid", {31'd0, rv1}, 0);
        check("reset1_busy", {31'd0, busy1}, 0);
        rst_n = 1;
        @(posedge clk); #1;
        rr8 = 1; rr1 = 1;

        // Basic vectors.
        op8(0, 8'd200, 8'd55, 8'd145, 0);
        op8(1, 8'd5, 8'd9, 8'd252, 1);
        op8(0, 8'd0, 8'd255, 8'd1, 1);
        op8(1, 8'd77, 8'd77, 8'd0, 0);

        // Both requesters continuously valid: grants must alternate 0,1,0,1.
        r0v8 = 1; r0a8 = 8'd100; r0b8 = 8'd1;
        r1v8 = 1; r1a8 = 8'd1;   r1b8 = 8'd2;
        for (int i = 0; i < 4; i++) begin
            got = 0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clk);
                if (r0rdy8 || r1rdy8) got = 1;
            end
            check("rr_grant_wait", {31'd0, got}, 1);
            if (got) begin
                check("rr_order", {31'd0, r1rdy8}, i % 2);
                e.id = r1rdy8;
                e.diff = r1rdy8 ? 8'd255 : 8'd99;
                e.borrow = r1rdy8;
                q8.push_back(e);
                $display("W8 rr grant %0d id=%0d", i, r1rdy8);
            end
            @(posedge clk);
        end
        #1;
        r0v8 = 0; r1v8 = 0;
        repeat (12) @(posedge clk);
        #1;

        // Stall in DONE for 20 cycles with another request pending.
        rr8 = 0;
        op8(0, 8'd50, 8'd20, 8'd30, 0);
        r1v8 = 1; r1a8 = 8'd9; r1b8 = 8'd4;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, rv8}, 1);
            check("stall_diff", {24'd0, rd8}, 30);
            check("stall_id", {31'd0, rid8}, 0);
            check("stall_busy", {31'd0, busy8}, 1);
            check("stall_rdy1", {31'd0, r1rdy8}, 0);
        end
        @(posedge clk); #1;
        rr8 = 1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("next_grant", {31'd0, r1rdy8}, 1);
        if (r1rdy8) begin
            e.diff = 8'd5; e.borrow = 0; e.id = 1;
            q8.push_back(e);
        end
        @(posedge clk); #1;
        r1v8 = 0;
        repeat (12) @(posedge clk);
        #1;

        // Reset during RUN bit 3, then confirm pointer restart and normal latency.
        r0v8 = 1; r0a8 = 8'd123; r0b8 = 8'd45;
        wait_ready8(0, got);
        @(posedge clk); #1;
        r0v8 = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 0;
        r1v8 = 1;
        #1;
        check_zero8("midreset");
        @(negedge clk);
        r1v8 = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        r1v8 = 1; r1a8 = 8'd3; r1b8 = 8'd10;
        op8(0, 8'd10, 8'd3, 8'd7, 0);
        wait_ready8(1, got);
        if (got) begin
            e.diff = 8'd249; e.borrow = 1; e.id = 1;
            q8.push_back(e);
        end
        @(posedge clk); #1;
        r1v8 = 0;
        repeat (12) @(posedge clk);
        #1;

        // Single-bit instance truth table.
        op1(0, 1'b0, 1'b0, 1'b0, 1'b0);
        op1(1, 1'b0, 1'b1, 1'b1, 1'b1);
        op1(0, 1'b1, 1'b0, 1'b1, 1'b0);
        op1(1, 1'b1, 1'b1, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("q8_drained", q8.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
